// File: rtl/uart_tx_arbiter_if.sv
// Bus between the requester channels, the arbiter and the UART transmitter.
// master: arbiter side. slave: requesters plus transmitter side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8,
  parameter int ID_BITS   = 2
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATA_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         tx_start;
  logic [DATA_BITS-1:0]         tx_data;
  logic                         tx_done;
  logic                         busy;
  logic [ID_BITS-1:0]           grant_id;

  modport master (
    input  req_valid, req_data, tx_done,
    output req_ready, tx_start, tx_data, busy, grant_id
  );

  modport slave (
    output req_valid, req_data, tx_done,
    input  req_ready, tx_start, tx_data, busy, grant_id
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ channels.
// Optional feature macro UART_TX_ARB_HEADER_EN: each grant is preceded by an
// internally generated header byte {4'hA, zero pad, grant_id}.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8,
  parameter int ID_BITS   = 2
) (
  input  logic              clk_50MHz,
  input  logic              reset,
  uart_tx_arbiter_if.master bus
);

`ifdef UART_TX_ARB_HEADER_EN
  typedef enum logic [2:0] {IDLE, DATA_START, DATA_WAIT, HDR_START, HDR_WAIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA_START, DATA_WAIT} state_t;
`endif

  state_t               state_q, state_d;
  logic [ID_BITS-1:0]   last_grant_q;
  logic [ID_BITS-1:0]   grant_id_q;
  logic [DATA_BITS-1:0] data_q;

  logic                 win_vld;
  logic [ID_BITS-1:0]   win_id;
  logic [ID_BITS:0]     idx;
  logic                 grant;

  // Circular search starting one past the last granted channel.
  always_comb begin
    win_vld = 1'b0;
    win_id  = last_grant_q;
    idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, last_grant_q} + (ID_BITS+1)'(k);
      if (idx >= (ID_BITS+1)'(NUM_REQ)) idx = idx - (ID_BITS+1)'(NUM_REQ);
      if (!win_vld && bus.req_valid[idx[ID_BITS-1:0]]) begin
        win_vld = 1'b1;
        win_id  = idx[ID_BITS-1:0];
      end
    end
  end

  // A grant can only happen from IDLE; tx_done is never looked at here.
  assign grant = (state_q == IDLE) && win_vld;

  // State register.
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; tx_done only matters in the *_WAIT states.
  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef UART_TX_ARB_HEADER_EN
      IDLE:       if (win_vld) state_d = HDR_START;
      HDR_START:  state_d = HDR_WAIT;
      HDR_WAIT:   if (bus.tx_done) state_d = DATA_START;
`else
      IDLE:       if (win_vld) state_d = DATA_START;
`endif
      DATA_START: state_d = DATA_WAIT;
      DATA_WAIT:  if (bus.tx_done) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Capture byte and winner at the grant; pointer moves only on a grant.
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      last_grant_q <= ID_BITS'(NUM_REQ-1);
      grant_id_q   <= '0;
      data_q       <= '0;
    end else if (grant) begin
      last_grant_q <= win_id;
      grant_id_q   <= win_id;
      data_q       <= bus.req_data[win_id*DATA_BITS +: DATA_BITS];
    end
  end

`ifdef UART_TX_ARB_HEADER_EN
  logic [7:0] hdr_byte;
  assign hdr_byte = {4'hA, {(4-ID_BITS){1'b0}}, grant_id_q};
`endif

  // Outputs: ready is a same-cycle pulse, start follows the *_START states.
  always_comb begin
    bus.req_ready = '0;
    if (grant) bus.req_ready[win_id] = 1'b1;
    bus.tx_start  = (state_q == DATA_START);
    bus.busy      = (state_q != IDLE);
    bus.grant_id  = grant_id_q;
    bus.tx_data   = data_q;
`ifdef UART_TX_ARB_HEADER_EN
    if (state_q == HDR_START) bus.tx_start = 1'b1;
    if (state_q == HDR_START || state_q == HDR_WAIT) bus.tx_data = DATA_BITS'(hdr_byte);
`endif
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a per-cycle vector table for the base
// build plus hand-written sequences for reset, round-robin and header frames.
module tb_uart_tx_arbiter;
  logic clk_50MHz = 1'b0;
  logic reset     = 1'b0;
  int   checks    = 0;
  int   errors    = 0;

  uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_BITS(8), .ID_BITS(2)) bus ();

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_BITS(8), .ID_BITS(2)) dut (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .bus       (bus)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  typedef struct {
    logic [3:0]  rv;
    logic [31:0] rd;
    logic        done;
    logic [3:0]  ready;
    logic        start;
    logic        busy;
    logic [1:0]  gid;
    logic [7:0]  txd;
  } tv_t;

  logic [7:0] exp_bytes[$];
  logic [1:0] exp_gnt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_grant(input logic [1:0] g, input logic [7:0] b);
    exp_gnt.push_back(g);
`ifdef UART_TX_ARB_HEADER_EN
    exp_bytes.push_back({6'b101000, g});
`endif
    exp_bytes.push_back(b);
  endtask

  task automatic pulse_reset();
    bus.req_valid = '0;
    bus.tx_done   = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk_50MHz);
    @(negedge clk_50MHz);
    reset = 1'b1;
  endtask

  // Requesters hold valid until their ready; a simple transmitter answers
  // each tx_start with tx_done three cycles later.
  task automatic run_seq(input logic [3:0] rv0, input logic [31:0] rd, input int budget);
    logic [3:0] rv_l;
    logic [3:0] oh;
    logic [1:0] g;
    logic [1:0] last_g;
    int cnt;
    int c;
    bit done_all;
    rv_l = rv0; cnt = 0; c = 0; done_all = 0; last_g = '0;
    bus.req_data = rd;
    while (!done_all && c < budget) begin
      @(posedge clk_50MHz); #1;
      bus.tx_done   = (cnt == 1);
      if (cnt > 0) cnt--;
      bus.req_valid = rv_l;
      @(negedge clk_50MHz);
      if (bus.req_ready != 0) begin
        if (exp_gnt.size() == 0) chk("extra_ready", 32'(bus.req_ready), 32'd0);
        else begin
          g  = exp_gnt.pop_front();
          oh = 4'b0001 << g;
          chk("seq_ready", 32'(bus.req_ready), 32'(oh));
          last_g = g;
        end
        rv_l = rv_l & ~bus.req_ready;
      end
      if (bus.tx_start) begin
        chk("seq_gid", 32'(bus.grant_id), 32'(last_g));
        if (exp_bytes.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_start act=%h exp=none @%0t", bus.tx_data, $time);
        end else chk("seq_txd", 32'(bus.tx_data), 32'(exp_bytes.pop_front()));
        cnt = 3;
      end
      if (exp_bytes.size() == 0 && exp_gnt.size() == 0 && cnt == 0 && !bus.busy && rv_l == 0)
        done_all = 1;
      c++;
    end
    bus.tx_done = 1'b0;
    chk("seq_complete", 32'(done_all), 32'd1);
    exp_bytes.delete();
    exp_gnt.delete();
  endtask

  initial begin
    tv_t tv[25];
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.tx_done   = 1'b0;

    // Reset values while reset is held low.
    #5;
    chk("rst_start", 32'(bus.tx_start), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_txd",   32'(bus.tx_data), 32'd0);
    chk("rst_gid",   32'(bus.grant_id), 32'd0);
    repeat (2) @(posedge clk_50MHz);
    @(negedge clk_50MHz);
    reset = 1'b1;

`ifndef UART_TX_ARB_HEADER_EN
    //          rv      rd             done ready  st busy gid  txd
    // ch2 single byte 0x5A
    tv[0]  = '{4'b0100, 32'h005A0000, 0, 4'b0100, 0, 0, 2'd0, 8'h00};
    tv[1]  = '{4'b0000, 32'h005A0000, 0, 4'b0000, 1, 1, 2'd2, 8'h5A};
    tv[2]  = '{4'b0000, 32'h005A0000, 0, 4'b0000, 0, 1, 2'd2, 8'h5A};
    tv[3]  = '{4'b0000, 32'h005A0000, 1, 4'b0000, 0, 1, 2'd2, 8'h5A};
    tv[4]  = '{4'b0000, 32'h005A0000, 0, 4'b0000, 0, 0, 2'd2, 8'h5A};
    // tx_done in IDLE is ignored
    tv[5]  = '{4'b0000, 32'h005A0000, 1, 4'b0000, 0, 0, 2'd2, 8'h5A};
    tv[6]  = '{4'b0000, 32'h005A0000, 0, 4'b0000, 0, 0, 2'd2, 8'h5A};
    // ch1 0x43; tx_done during DATA_START is ignored
    tv[7]  = '{4'b0010, 32'h00004300, 0, 4'b0010, 0, 0, 2'd2, 8'h5A};
    tv[8]  = '{4'b0000, 32'h00004300, 1, 4'b0000, 1, 1, 2'd1, 8'h43};
    tv[9]  = '{4'b0000, 32'h00004300, 0, 4'b0000, 0, 1, 2'd1, 8'h43};
    tv[10] = '{4'b0000, 32'h00004300, 1, 4'b0000, 0, 1, 2'd1, 8'h43};
    tv[11] = '{4'b0000, 32'h00004300, 0, 4'b0000, 0, 0, 2'd1, 8'h43};
    // ch0 and ch3 always valid: alternate 3,0,3,0 (pointer at 1)
    tv[12] = '{4'b1001, 32'hC30000C0, 0, 4'b1000, 0, 0, 2'd1, 8'h43};
    tv[13] = '{4'b1001, 32'hC30000C0, 0, 4'b0000, 1, 1, 2'd3, 8'hC3};
    tv[14] = '{4'b1001, 32'hC30000C0, 1, 4'b0000, 0, 1, 2'd3, 8'hC3};
    tv[15] = '{4'b1001, 32'hC30000C0, 0, 4'b0001, 0, 0, 2'd3, 8'hC3};
    tv[16] = '{4'b1001, 32'hC30000C0, 0, 4'b0000, 1, 1, 2'd0, 8'hC0};
    tv[17] = '{4'b1001, 32'hC30000C0, 1, 4'b0000, 0, 1, 2'd0, 8'hC0};
    tv[18] = '{4'b1001, 32'hC30000C0, 0, 4'b1000, 0, 0, 2'd0, 8'hC0};
    tv[19] = '{4'b1001, 32'hC30000C0, 0, 4'b0000, 1, 1, 2'd3, 8'hC3};
    tv[20] = '{4'b1001, 32'hC30000C0, 1, 4'b0000, 0, 1, 2'd3, 8'hC3};
    tv[21] = '{4'b1001, 32'hC30000C0, 0, 4'b0001, 0, 0, 2'd3, 8'hC3};
    tv[22] = '{4'b0000, 32'hC30000C0, 0, 4'b0000, 1, 1, 2'd0, 8'hC0};
    tv[23] = '{4'b0000, 32'hC30000C0, 1, 4'b0000, 0, 1, 2'd0, 8'hC0};
    tv[24] = '{4'b0000, 32'hC30000C0, 0, 4'b0000, 0, 0, 2'd0, 8'hC0};

    for (int i = 0; i < 25; i++) begin
      @(posedge clk_50MHz); #1;
      bus.req_valid = tv[i].rv;
      bus.req_data  = tv[i].rd;
      bus.tx_done   = tv[i].done;
      @(negedge clk_50MHz);
      chk($sformatf("tv%0d_ready", i), 32'(bus.req_ready), 32'(tv[i].ready));
      chk($sformatf("tv%0d_start", i), 32'(bus.tx_start),  32'(tv[i].start));
      chk($sformatf("tv%0d_busy", i),  32'(bus.busy),      32'(tv[i].busy));
      chk($sformatf("tv%0d_gid", i),   32'(bus.grant_id),  32'(tv[i].gid));
      chk($sformatf("tv%0d_txd", i),   32'(bus.tx_data),   32'(tv[i].txd));
    end
    bus.tx_done = 1'b0;
`endif

    // Reset asserted during DATA_WAIT: outputs clear immediately, nothing replays.
    @(posedge clk_50MHz); #1;
    bus.req_valid = 4'b0010;
    bus.req_data  = 32'h00007700;
    @(negedge clk_50MHz);
    chk("mid_ready", 32'(bus.req_ready), 32'h2);
    @(posedge clk_50MHz); #1;
    bus.req_valid = '0;
`ifdef UART_TX_ARB_HEADER_EN
    @(posedge clk_50MHz); #1;
    bus.tx_done = 1'b1;
    @(posedge clk_50MHz); #1;
    bus.tx_done = 1'b0;
`endif
    @(negedge clk_50MHz);
    chk("mid_start", 32'(bus.tx_start), 32'd1);
    chk("mid_txd",   32'(bus.tx_data), 32'h77);
    @(posedge clk_50MHz); #1;
    @(negedge clk_50MHz);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    #3 reset = 1'b0;
    #1;
    chk("arst_start", 32'(bus.tx_start), 32'd0);
    chk("arst_busy",  32'(bus.busy), 32'd0);
    chk("arst_ready", 32'(bus.req_ready), 32'd0);
    chk("arst_txd",   32'(bus.tx_data), 32'd0);
    chk("arst_gid",   32'(bus.grant_id), 32'd0);
    @(posedge clk_50MHz);
    @(negedge clk_50MHz);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_50MHz);
      chk("post_rst_start", 32'(bus.tx_start), 32'd0);
      chk("post_rst_busy",  32'(bus.busy), 32'd0);
    end
    push_grant(2'd1, 8'h43);
    run_seq(4'b0010, 32'h00004300, 40);

    // All four channels valid out of reset: order 0,1,2,3.
    pulse_reset();
    push_grant(2'd0, 8'h11);
    push_grant(2'd1, 8'h22);
    push_grant(2'd2, 8'h33);
    push_grant(2'd3, 8'h44);
    run_seq(4'b1111, 32'h44332211, 120);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
